sobel_axis_framer: RTL and testbench

SOBEL_AXIS_FRAMER -- requirements
Module: sobel_axis_framer

---
 rtl/sobel_axis_framer.sv | 106 ++++++++++
 tb/tb_sobel_axis_framer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sobel_axis_framer.sv
// Frames a raw Sobel magnitude stream into AXI4-Stream video (tuser/tlast) through a show-ahead FIFO.
// Optional build macro SOBEL_THRESHOLD_EN adds a threshold port and binarises stored pixels.
module sobel_axis_framer #(
  parameter int unsigned OUT_WIDTH  = 1918,
  parameter int unsigned OUT_HEIGHT = 1078,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output logic [23:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
`ifdef SOBEL_THRESHOLD_EN
  ,
  input  logic [7:0]                    threshold
`endif
);

  localparam int unsigned CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int unsigned RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 10;

  logic [CW-1:0] col_q, col_d, col_tag;
  logic [RW-1:0] row_q, row_d, row_tag;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q;
  logic          full, empty, push, pop, drop;
  logic [7:0]    pix_w;
  logic [EW-1:0] wdata, head;

`ifdef SOBEL_THRESHOLD_EN
  assign pix_w = (pixel_in >= threshold) ? 8'hFF : 8'h00;
`else
  assign pix_w = pixel_in;
`endif

  // Geometry tagging, FIFO control and counter advance
  always_comb begin
    col_tag = frame_start ? '0 : col_q;
    row_tag = frame_start ? '0 : row_q;
    full    = (count_q == LW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    pop     = !empty && m_axis_tready;
    push    = pixel_valid && (!full || pop);
    drop    = pixel_valid && full && !pop;
    wdata   = {(col_tag == '0) && (row_tag == '0), col_tag == CW'(OUT_WIDTH - 1), pix_w};
    col_d   = col_tag;
    row_d   = row_tag;
    if (pixel_valid) begin
      if (col_tag == CW'(OUT_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_tag == RW'(OUT_HEIGHT - 1)) ? '0 : row_tag + RW'(1);
      end else begin
        col_d = col_tag + CW'(1);
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Show-ahead head entry; memory is cleared on reset so outputs read zero
  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tdata  = {head[7:0], head[7:0], head[7:0]};
  assign m_axis_tlast  = head[8];
  assign m_axis_tuser  = head[9];
  assign m_axis_tvalid = !empty;
  assign fill_level    = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_sobel_axis_framer.sv
// Self-checking bench for sobel_axis_framer: directed scenarios plus random traffic against a queue model.
module tb_sobel_axis_framer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic        pixel_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, overflow;
  logic [2:0]  fill_level;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position as a linear index, FIFO as a queue of {tuser,tlast,pixel}
  logic [9:0] mq[$];
  int         pos = 0;
  bit         movf = 1'b0;

  sobel_axis_framer #(.OUT_WIDTH(W), .OUT_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    if (mq.size() != 0) begin
      chk("tdata", 32'(m_axis_tdata), 32'({mq[0][7:0], mq[0][7:0], mq[0][7:0]}));
      chk("tlast", 32'(m_axis_tlast), 32'(mq[0][8]));
      chk("tuser", 32'(m_axis_tuser), 32'(mq[0][9]));
    end
  endtask

  // One clock: check current outputs, drive inputs, then advance the model at the edge
  task automatic cyc(input logic pv, input logic [7:0] px, input logic fs,
                     input logic rdy, input logic r);
    bit         do_pop, is_full;
    logic [9:0] ent;
    check_outputs();
    pixel_valid   = pv;
    pixel_in      = px;
    frame_start   = fs;
    m_axis_tready = rdy;
    rst           = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      pos  = 0;
      movf = 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      is_full = (mq.size() == D);
      if (fs) pos = 0;
      ent = {pos == 0, (pos % W) == W - 1, px};
      if (pv) begin
        if (is_full && !do_pop) movf = 1'b1;
        pos = (pos + 1) % (W * H);
      end
      if (do_pop) void'(mq.pop_front());
      if (pv && (!is_full || do_pop)) mq.push_back(ent);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    // Reset with a pixel presented, which must be ignored
    cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
    check_reset_state();

    // Eight-pixel frame streamed with tready high
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Overflow with tready low, then drain
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    chk("ovf_fill", 32'(fill_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(m_axis_tdata), 32'h202020);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_reset_state();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_fill", 32'(fill_level), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // frame_start on the third pixel of a line
    cyc(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h42, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h43 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset with three buffered pixels
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_fill", 32'(fill_level), 32'd3);
    cyc(1'b1, 8'h5F, 1'b0, 1'b0, 1'b1);
    check_reset_state();
    cyc(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
    chk("post_rst_tuser", 32'(m_axis_tuser), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
